// File: rtl/output_writeback_pkg.sv
// Shared definitions for the output writeback stage: FSM state encodings, address/config widths.
package output_writeback_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CFG_W  = 8;
  localparam int unsigned NPIX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Pixels per output channel plane.
  function automatic logic [NPIX_W-1:0] pix_count(input logic [CFG_W-1:0] nrow,
                                                 input logic [CFG_W-1:0] ncol);
    return NPIX_W'(nrow) * NPIX_W'(ncol);
  endfunction

endpackage

// File: rtl/output_writeback_out_quant.sv
// Requantizer: round half up, arithmetic shift by decimal, saturate to width.
// Optional macro RELU_EN clamps negative results to zero.
module output_writeback_out_quant #(
  parameter int unsigned accw    = 16,
  parameter int unsigned width   = 8,
  parameter int unsigned decimal = 4
) (
  input  logic [accw-1:0]  acc,
  output logic [width-1:0] q_c
);

  localparam int unsigned EW = accw + 1;
  localparam logic signed [EW-1:0] HALF = EW'(2 ** (decimal - 1));
  localparam logic signed [EW-1:0] MAXV = EW'((2 ** (width - 1)) - 1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  logic signed [EW-1:0] acc_ext;
  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] shifted;
  logic [width-1:0]     sat;

  // One guard bit keeps the rounding add from overflowing.
  always_comb begin
    acc_ext = EW'($signed(acc));
    rounded = acc_ext + HALF;
    shifted = rounded >>> decimal;
    if (shifted > MAXV) begin
      sat = MAXV[width-1:0];
    end else if (shifted < MINV) begin
      sat = MINV[width-1:0];
    end else begin
      sat = shifted[width-1:0];
    end
`ifdef RELU_EN
    q_c = sat[width-1] ? '0 : sat;
`else
    q_c = sat;
`endif
  end

endmodule

// File: rtl/output_writeback.sv
// Output writeback: requantizes each accepted cols-wide PE vector and serializes it as BRAM
// writes, walking output channels in tiles of cols. Macro RELU_EN clamps negative results to 0.
module output_writeback
  import output_writeback_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned decimal = 4,
  parameter int unsigned cols    = 4,
  parameter int unsigned accw    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CFG_W-1:0]       do_ch,
  input  logic [CFG_W-1:0]       orows,
  input  logic [CFG_W-1:0]       ocols,
  input  logic [ADDR_W-1:0]      outaddr,
  input  logic [cols*accw-1:0]   pe_out,
  input  logic                   out_valid,
  output logic                   out_ready,
  output logic                   wea,
  output logic [ADDR_W-1:0]      memaddr,
  output logic [width-1:0]       mem_in,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned COL_W = $clog2(cols + 1);
  localparam int unsigned SEL_W = (cols > 1) ? $clog2(cols) : 1;

  state_e              state_q, state_d;
  logic [CFG_W-1:0]    do_q, do_d;
  logic [NPIX_W-1:0]   npix_q, npix_d;
  logic [NPIX_W-1:0]   pix_q, pix_d;
  logic [NPIX_W-1:0]   tile_ch_q, tile_ch_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [cols*accw-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
  logic [ADDR_W-1:0]   memaddr_q, memaddr_d;
  logic [width-1:0]    mem_in_q, mem_in_d;
  logic                out_ready_q, out_ready_d;
  logic                wea_q, wea_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept_c;
  logic [SEL_W-1:0]    col_sel_c;
  logic [accw-1:0]     src_a [cols];
  logic [accw-1:0]     acc_sel_c;
  logic [width-1:0]    quant_c;
  logic [NPIX_W-1:0]   ch_c;
  logic                ch_en_c;
  logic [NPIX_W-1:0]   tile_next_c;
  logic                pix_last_c;
  logic                col_more_c;

  // Column 0 is emitted straight from pe_out on the accept edge; later columns from the capture.
  assign accept_c    = (state_q == ST_WAIT) && out_valid && out_ready_q;
  assign col_sel_c   = accept_c ? '0 : col_q[SEL_W-1:0];
  assign ch_c        = tile_ch_q + NPIX_W'(col_sel_c);
  assign ch_en_c     = ch_c < NPIX_W'(do_q);
  assign tile_next_c = tile_ch_q + NPIX_W'(cols);
  assign pix_last_c  = (pix_q + NPIX_W'(1)) == npix_q;
  assign col_more_c  = col_q < COL_W'(cols);

  always_comb begin
    for (int c = 0; c < int'(cols); c++) begin
      src_a[c] = accept_c ? pe_out[c*accw +: accw] : vec_q[c*accw +: accw];
    end
  end

  assign acc_sel_c = src_a[col_sel_c];

  output_writeback_out_quant #(
    .accw    (accw),
    .width   (width),
    .decimal (decimal)
  ) u_out_quant (
    .acc (acc_sel_c),
    .q_c (quant_c)
  );

  always_comb begin
    state_d     = state_q;
    do_d        = do_q;
    npix_d      = npix_q;
    pix_d       = pix_q;
    tile_ch_d   = tile_ch_q;
    col_d       = col_q;
    vec_d       = vec_q;
    pix_addr_d  = pix_addr_q;
    memaddr_d   = memaddr_q;
    mem_in_d    = mem_in_q;
    out_ready_d = 1'b0;
    wea_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          do_d        = do_ch;
          npix_d      = pix_count(orows, ocols);
          pix_d       = '0;
          tile_ch_d   = '0;
          pix_addr_d  = outaddr;
          busy_d      = 1'b1;
          out_ready_d = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        out_ready_d = !accept_c;
        if (accept_c) begin
          vec_d     = pe_out;
          wea_d     = ch_en_c;
          memaddr_d = pix_addr_q;
          mem_in_d  = quant_c;
          col_d     = COL_W'(1);
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (col_more_c) begin
          wea_d     = ch_en_c;
          memaddr_d = memaddr_q + npix_q[ADDR_W-1:0];
          mem_in_d  = quant_c;
          col_d     = col_q + COL_W'(1);
        end else if (pix_last_c) begin
          // Next tile's pixel 0 sits right after the last column's plane entry.
          pix_d      = '0;
          tile_ch_d  = tile_next_c;
          pix_addr_d = memaddr_q + ADDR_W'(1);
          if (tile_next_c >= NPIX_W'(do_q)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            out_ready_d = 1'b1;
            state_d     = ST_WAIT;
          end
        end else begin
          pix_d       = pix_q + NPIX_W'(1);
          pix_addr_d  = pix_addr_q + ADDR_W'(1);
          out_ready_d = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      do_q        <= '0;
      npix_q      <= '0;
      pix_q       <= '0;
      tile_ch_q   <= '0;
      col_q       <= '0;
      vec_q       <= '0;
      pix_addr_q  <= '0;
      memaddr_q   <= '0;
      mem_in_q    <= '0;
      out_ready_q <= 1'b0;
      wea_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      do_q        <= do_d;
      npix_q      <= npix_d;
      pix_q       <= pix_d;
      tile_ch_q   <= tile_ch_d;
      col_q       <= col_d;
      vec_q       <= vec_d;
      pix_addr_q  <= pix_addr_d;
      memaddr_q   <= memaddr_d;
      mem_in_q    <= mem_in_d;
      out_ready_q <= out_ready_d;
      wea_q       <= wea_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_ready = out_ready_q;
  assign wea       = wea_q;
  assign memaddr   = memaddr_q;
  assign mem_in    = mem_in_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_output_writeback.sv
// Bench for output_writeback: requantization table, directed tiling/addressing/wrap/abort
// sequences, and randomized jobs checked against a plane-address reference model.
module tb_output_writeback;

  localparam int W    = 8;
  localparam int DEC  = 4;
  localparam int COLS = 4;
  localparam int ACCW = 16;
  localparam int VW   = COLS * ACCW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    do_ch;
  logic [7:0]    orows;
  logic [7:0]    ocols;
  logic [9:0]    outaddr;
  logic [VW-1:0] pe_out;
  logic          out_valid;
  logic          out_ready;
  logic          wea;
  logic [9:0]    memaddr;
  logic [W-1:0]  mem_in;
  logic          busy;
  logic          done;

  output_writeback #(.width(W), .decimal(DEC), .cols(COLS), .accw(ACCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .do_ch     (do_ch),
    .orows     (orows),
    .ocols     (ocols),
    .outaddr   (outaddr),
    .pe_out    (pe_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wea       (wea),
    .memaddr   (memaddr),
    .mem_in    (mem_in),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write/done monitor sampled on the falling edge.
  logic [9:0]   got_addr[$];
  logic [W-1:0] got_data[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int viol = 0;

  always @(negedge clk) begin
    if (wea) begin
      got_addr.push_back(memaddr);
      got_data.push_back(mem_in);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ((wea && out_ready) || (wea && !busy) || (done && busy)) viol++;
  end

  // Reference requantizer: floor((x + 2^(DEC-1)) / 2^DEC), saturated.
  function automatic int qmodel(input logic [ACCW-1:0] x);
    int v;
    int r;
    v = int'($signed(x)) + (1 << (DEC - 1));
    if (v >= 0) r = v / (1 << DEC);
    else        r = -((-v + (1 << DEC) - 1) / (1 << DEC));
    if (r > (1 << (W - 1)) - 1) r = (1 << (W - 1)) - 1;
    if (r < -(1 << (W - 1)))    r = -(1 << (W - 1));
`ifdef RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    int s;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      if ($urandom_range(0, 3) == 0) s = int'($urandom);
      else                           s = int'($urandom_range(0, 4400)) - 2200;
      v[c*ACCW +: ACCW] = ACCW'(s);
    end
    return v;
  endfunction

  logic [VW-1:0] vin[$];

  task automatic run_job(input string tag, input int d, input int r, input int c,
                         input int base, input bit hold);
    logic [VW-1:0] vecs[$];
    logic [VW-1:0] tmp;
    int exp_addr[$];
    int exp_data[$];
    int acc_cyc[$];
    int ntile;
    int npix;
    int nvec;
    int nchk;
    int bad;
    bit ok;
    ntile = (d + COLS - 1) / COLS;
    npix  = r * c;
    nvec  = ntile * npix;
    ok    = 1'b1;
    for (int v = 0; v < nvec; v++) begin
      if (vin.size() > 0) vecs.push_back(vin.pop_front());
      else                vecs.push_back(rand_vec());
    end
    vin.delete();
    for (int t = 0; t < ntile; t++)
      for (int p = 0; p < npix; p++) begin
        tmp = vecs[t*npix + p];
        for (int k = 0; k < COLS; k++)
          if (t*COLS + k < d) begin
            exp_addr.push_back((base + (t*COLS + k) * npix + p) % 1024);
            exp_data.push_back(qmodel(tmp[k*ACCW +: ACCW]) & 8'hFF);
          end
      end

    @(posedge clk); #1;
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    viol = 0;
    do_ch = 8'(d); orows = 8'(r); ocols = 8'(c); outaddr = 10'(base);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int v = 0; v < nvec && ok; v++) begin
      bit got;
      int waitc;
      got = 1'b0;
      waitc = 0;
      while (!got && ok) begin
        if (hold || $urandom_range(0, 2) != 0) begin
          out_valid = 1'b1;
          pe_out = vecs[v];
        end else begin
          out_valid = 1'b0;
          pe_out = rand_vec();
        end
        @(negedge clk);
        got = out_valid && out_ready;
        @(posedge clk); #1;
        if (got) begin
          acc_cyc.push_back(cyc);
          out_valid = 1'b0;
          pe_out = rand_vec();
        end else if (++waitc > 40) begin
          check({tag, "/accept_timeout"}, 32'(v), 32'(nvec));
          ok = 1'b0;
        end
      end
    end
    out_valid = 1'b0;
    for (int i = 0; i < 30 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;

    check({tag, "/nwrites"}, got_addr.size(), exp_addr.size());
    nchk = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s/addr[%0d]", tag, i), 32'(got_addr[i]), exp_addr[i]);
      check($sformatf("%s/data[%0d]", tag, i), 32'(got_data[i]), exp_data[i]);
    end
    check({tag, "/done_cnt"}, done_cnt, 1);
    if (ok && acc_cyc.size() > 0) check({tag, "/done_latency"}, done_cyc - acc_cyc[$], COLS);
    check({tag, "/protocol"}, viol, 0);
    check({tag, "/busy_end"}, 32'(busy), 0);
    if (hold && acc_cyc.size() > 1) begin
      bad = 0;
      for (int i = 1; i < acc_cyc.size(); i++)
        if (acc_cyc[i] - acc_cyc[i-1] != COLS + 1) bad++;
      check({tag, "/accept_spacing"}, bad, 0);
    end
  endtask

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  exp_lin;
    logic [7:0]  exp_relu;
  } qvec_t;

  qvec_t tbl[12];

  initial begin
    logic [VW-1:0] v;
    logic [7:0] e;

    tbl[0]  = '{16'h0180, 8'h18, 8'h18};
    tbl[1]  = '{16'h0008, 8'h01, 8'h01};
    tbl[2]  = '{16'h7FFF, 8'h7F, 8'h7F};
    tbl[3]  = '{16'h8000, 8'h80, 8'h00};
    tbl[4]  = '{16'hFFF8, 8'h00, 8'h00};
    tbl[5]  = '{16'h0007, 8'h00, 8'h00};
    tbl[6]  = '{16'h0017, 8'h01, 8'h01};
    tbl[7]  = '{16'hFFE7, 8'hFE, 8'h00};
    tbl[8]  = '{16'h07F7, 8'h7F, 8'h7F};
    tbl[9]  = '{16'h07F8, 8'h7F, 8'h7F};
    tbl[10] = '{16'hF808, 8'h81, 8'h00};
    tbl[11] = '{16'hF807, 8'h80, 8'h00};

    // Reset held with start asserted.
    rst = 1'b0; start = 1'b1; out_valid = 1'b0; pe_out = '0;
    do_ch = 8'd4; orows = 8'd1; ocols = 8'd1; outaddr = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/wea", 32'(wea), 0);
    check("rst/out_ready", 32'(out_ready), 0);
    check("rst/busy", 32'(busy), 0);
    check("rst/done", 32'(done), 0);
    check("rst/memaddr", 32'(memaddr), 0);
    check("rst/mem_in", 32'(mem_in), 0);
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle/out_ready", 32'(out_ready), 0);
    check("idle/busy", 32'(busy), 0);

    // Requantization table, one single-channel job per entry.
    for (int i = 0; i < 12; i++) begin
      v = rand_vec();
      v[ACCW-1:0] = tbl[i].acc;
      vin.push_back(v);
      run_job($sformatf("qtbl%0d", i), 1, 1, 1, int'($urandom_range(0, 1023)), 1'b1);
`ifdef RELU_EN
      e = tbl[i].exp_relu;
`else
      e = tbl[i].exp_lin;
`endif
      if (got_data.size() > 0) check($sformatf("qtbl%0d/value", i), 32'(got_data[0]), 32'(e));
    end

    // Four columns of one vector.
    vin.push_back({16'h8000, 16'h7FFF, 16'h0008, 16'h0180});
    run_job("qvec", 4, 1, 1, 10, 1'b1);
    if (got_data.size() == 4) begin
      check("qvec/c0", 32'(got_data[0]), 32'h18);
      check("qvec/c1", 32'(got_data[1]), 32'h01);
      check("qvec/c2", 32'(got_data[2]), 32'h7F);
`ifdef RELU_EN
      check("qvec/c3", 32'(got_data[3]), 32'h00);
`else
      check("qvec/c3", 32'(got_data[3]), 32'h80);
`endif
    end

    // Plane addressing with backpressure.
    run_job("addr", 4, 2, 2, 100, 1'b1);
    if (got_addr.size() == 16) begin
      check("addr/p0c0", 32'(got_addr[0]), 100);
      check("addr/p0c1", 32'(got_addr[1]), 104);
      check("addr/p0c3", 32'(got_addr[3]), 112);
      check("addr/p3c3", 32'(got_addr[15]), 115);
    end

    // Partial last tile and address wrap.
    run_job("partial", 6, 1, 1, 0, 1'b1);
    run_job("wrap", 4, 1, 1, 1022, 1'b1);
    if (got_addr.size() == 4) check("wrap/c2", 32'(got_addr[2]), 0);

    // Abort during the second write.
    @(posedge clk); #1;
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    do_ch = 8'd4; orows = 8'd1; ocols = 8'd1; outaddr = 10'd1022; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_valid = 1'b1; pe_out = rand_vec();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_ready) break;
    end
    @(posedge clk); #1;
    out_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort/nwrites", got_addr.size(), 2);
    check("abort/done", done_cnt, 0);
    check("abort/busy", 32'(busy), 0);
    check("abort/out_ready", 32'(out_ready), 0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      run_job($sformatf("rnd%0d", j), int'($urandom_range(1, 12)), int'($urandom_range(1, 3)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
